// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the
// hold (stall) and clear (flush) controls of the IF_ID, ID_EX, EX_MEM and
// MEM_WB pipeline registers and the PC hold. Three conditions are resolved in
// priority order:
//   1. multi-cycle data-memory waits (whole pipe frozen),
//   2. taken branch / jump redirects resolved in EX (squash IF_ID and ID_EX),
//   3. load-use hazards detected in ID (one bubble into EX).
// A watchdog counts consecutive wait cycles. When memory hangs for
// MEM_TIMEOUT cycles, the pipe parks in ERR until err_clr is asserted.
//
// Parameters:
//   MEM_TIMEOUT : maximum consecutive wait cycles before ERR (>= 2)
//   CNT_W       : wait counter width, 2**CNT_W > MEM_TIMEOUT
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs1_addr/id_rs2_addr  source indices of the ID instruction
//   id_rs1_used/id_rs2_used  ID instruction actually reads rs1/rs2
//   ex_mem_r, ex_wr_addr     EX instruction is a load / its destination
//   ex_redirect              EX resolved a taken branch or jump
//   mem_req, mem_ready       MEM access issued / completed this cycle
//   err_clr                  clear of the timeout state
//   *_stall, pc_stall        hold controls
//   *_flush                  clear controls
//   mem_err                  sticky timeout flag
//
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit event counters:
//   perf_mem_stall, perf_lu_bubble, perf_redirect.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_mem_r,
  input  logic [4:0]  ex_wr_addr,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        err_clr,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        mem_wb_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_lu_bubble,
  output logic [31:0] perf_redirect,
`endif
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WCNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  // Unreset-qualified control values; rst is folded in at the ports.
  logic pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c, mem_wb_stall_c;
  logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, mem_err_c;

  logic load_use;
  logic mem_miss;
  logic run_redirect;
  logic run_bubble;

  // The EX load's destination must match a source register that ID really
  // reads. x0 is never a true dependency.
  assign load_use = ex_mem_r && (ex_wr_addr != 5'd0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_wr_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_wr_addr)));

  // A request that completes in the same cycle is a single-cycle access and
  // does not stall.
  assign mem_miss     = mem_req && !mem_ready;
  assign run_redirect = (state_q == S_RUN) && !mem_miss && ex_redirect;
  assign run_bubble   = (state_q == S_RUN) && !mem_miss && !ex_redirect && load_use;

  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_wb_stall_c = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    mem_err_c      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (mem_miss) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
          mem_wb_stall_c = 1'b1;
          state_d        = S_MEM_WAIT;
          wcnt_d         = CNT_W'(1);
        end else if (ex_redirect) begin
          // The ID instruction is squashed anyway, so any load-use it
          // carries is irrelevant.
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF_ID and inject one bubble into EX. The older
          // instructions keep moving.
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        // Redirect and load-use inputs come from frozen registers. They stay
        // valid and are acted on once the pipe is back in RUN.
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_stall_c  = 1'b1;
        ex_mem_stall_c = 1'b1;
        mem_wb_stall_c = 1'b1;
        if (mem_ready) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = S_ERR;
        end else if (wcnt_q != WCNT_MAX) begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end

      S_ERR: begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_stall_c  = 1'b1;
        ex_mem_stall_c = 1'b1;
        mem_wb_stall_c = 1'b1;
        mem_err_c      = 1'b1;
        if (err_clr) begin
          // Drop the hung access sitting in EX_MEM on the way out.
          ex_mem_flush_c = 1'b1;
          state_d        = S_RUN;
          wcnt_d         = '0;
        end
      end

      default: begin
        state_d = S_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Reset acts on the outputs immediately: every register is cleared and
  // nothing is held.
  assign pc_stall     = !rst && pc_stall_c;
  assign if_id_stall  = !rst && if_id_stall_c;
  assign id_ex_stall  = !rst && id_ex_stall_c;
  assign ex_mem_stall = !rst && ex_mem_stall_c;
  assign mem_wb_stall = !rst && mem_wb_stall_c;
  assign if_id_flush  = rst || if_id_flush_c;
  assign id_ex_flush  = rst || id_ex_flush_c;
  assign ex_mem_flush = rst || ex_mem_flush_c;
  assign mem_err      = !rst && mem_err_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_mem_stall_q, perf_lu_bubble_q, perf_redirect_q;
  logic        mem_stall_evt;

  // The RUN cycle that detects the miss is already a stall cycle.
  assign mem_stall_evt = (state_q == S_MEM_WAIT) || ((state_q == S_RUN) && mem_miss);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mem_stall_q <= '0;
      perf_lu_bubble_q <= '0;
      perf_redirect_q  <= '0;
    end else begin
      if (mem_stall_evt) perf_mem_stall_q <= perf_mem_stall_q + 32'd1;
      if (run_bubble)    perf_lu_bubble_q <= perf_lu_bubble_q + 32'd1;
      if (run_redirect)  perf_redirect_q  <= perf_redirect_q + 32'd1;
    end
  end

  assign perf_mem_stall = perf_mem_stall_q;
  assign perf_lu_bubble = perf_lu_bubble_q;
  assign perf_redirect  = perf_redirect_q;
`else
  // Keep the redirect and bubble qualifiers referenced when counters are
  // absent.
  logic unused_evt;
  assign unused_evt = run_redirect ^ run_bubble;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_wr_addr;
  logic       id_rs1_used, id_rs2_used, ex_mem_r, ex_redirect;
  logic       mem_req, mem_ready, err_clr;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_mem_stall, perf_lu_bubble, perf_redirect;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_r(ex_mem_r), .ex_wr_addr(ex_wr_addr),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .err_clr(err_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
`ifdef HAZARD_PERF_CNT_EN
    .perf_mem_stall(perf_mem_stall), .perf_lu_bubble(perf_lu_bubble),
    .perf_redirect(perf_redirect),
`endif
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Expected output vector order:
  // {pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id, id_ex, ex_mem flushes, mem_err}
  typedef struct packed {
    logic [8:0]  o;
    logic [31:0] pm;
    logic [31:0] pl;
    logic [31:0] pr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   done = 1'b0;
  int   cyc  = 0;

  // Reference model: an outstanding-access flag with a count of stall cycles
  // spent on it, plus a hung flag.
  bit          m_wait, m_hung;
  int          m_cnt;
  int unsigned m_pm, m_pl, m_pr;

  task automatic drive(input bit r, input bit [4:0] a1, input bit [4:0] a2,
                       input bit u1, input bit u2, input bit ld, input bit [4:0] wa,
                       input bit rd, input bit rq, input bit ry, input bit cl);
    exp_t e;
    bit   lu;
    rst = r; id_rs1_addr = a1; id_rs2_addr = a2; id_rs1_used = u1; id_rs2_used = u2;
    ex_mem_r = ld; ex_wr_addr = wa; ex_redirect = rd; mem_req = rq; mem_ready = ry;
    err_clr = cl;
    lu = ld && (wa != 0) && ((u1 && a1 == wa) || (u2 && a2 == wa));
    e.o = 9'b0; e.cyc = cyc;
    if (r) begin
      m_wait = 0; m_hung = 0; m_cnt = 0; m_pm = 0; m_pl = 0; m_pr = 0;
      e.o = 9'b00000_111_0;
      e.pm = 0; e.pl = 0; e.pr = 0;
    end else begin
      e.pm = m_pm; e.pl = m_pl; e.pr = m_pr;
      if (m_hung) begin
        e.o = {5'b11111, 2'b00, cl, 1'b1};
        if (cl) m_hung = 0;
      end else if (m_wait) begin
        e.o = 9'b11111_000_0;
        m_pm++;
        if (ry) m_wait = 0;
        else begin
          m_cnt++;
          if (m_cnt == TO) begin m_hung = 1; m_wait = 0; end
        end
      end else if (rq && !ry) begin
        e.o = 9'b11111_000_0;
        m_pm++; m_wait = 1; m_cnt = 1;
      end else if (rd) begin
        e.o = 9'b00000_110_0;
        m_pr++;
      end else if (lu) begin
        e.o = 9'b11000_010_0;
        m_pl++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    cyc++;
  endtask

  // Scoreboard monitor: compares on the falling edge, away from the update edge.
  int checks = 0;
  int errors = 0;
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_err};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL ctrl_vec cyc=%0d actual=%b required=%b", e.cyc, act, e.o);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if ({perf_mem_stall, perf_lu_bubble, perf_redirect} !== {e.pm, e.pl, e.pr}) begin
        errors++;
        $display("FAIL perf_cnt cyc=%0d actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                 e.cyc, perf_mem_stall, perf_lu_bubble, perf_redirect, e.pm, e.pl, e.pr);
      end
`endif
    end else if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    bit stuck;
    rst = 1'b1; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_mem_r = 0; ex_wr_addr = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0; err_clr = 0;
    @(posedge clk); #1;

    //     rst a1 a2 u1 u2 ld wa rd rq ry cl
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs2, then the same with x0 as destination.
    drive(0, 1, 5, 0, 1, 1, 5, 0, 0, 0, 0);
    drive(0, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 3, 0, 1, 0, 1, 3, 0, 0, 0, 0);
    // Redirect beats load-use.
    drive(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0);
    // Single-cycle access: no stall.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    // Three wait cycles then ready, redirect held throughout.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Timeout into ERR, ready ignored there, then clear.
    for (int i = 0; i < TO; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset mid-wait, then a full-length wait must again reach ERR.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TO + 1; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Counter scenario from reset: 2 bubbles, 1 redirect, a 3-cycle wait.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    drive(0, 2, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with small register indices to provoke hazards and
    // phases of stuck memory to reach the watchdog.
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 150) == 0) stuck = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 199) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4,
            stuck ? 1'b0 : 1'($urandom_range(0, 1)),
            $urandom_range(0, 6) == 0);
    end
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_timeout actual=%0d required=0", exp_q.size());
    $fatal(1, "monitor did not finish");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the stall and flush controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC enable.
- Resolves three conditions by priority: multi-cycle data-memory waits, taken-branch/jump redirects from EX, and load-use hazards detected in ID.
- Includes a wait-timeout watchdog that parks the pipeline on a hung memory.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before entering ERR; must be at least 2.
- CNT_W, 8: width of the wait-cycle counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1_addr  in  5  rs1 index of the instruction in ID
- id_rs2_addr  in  5  rs2 index of the instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_mem_r  in  1  instruction in EX is a load
- ex_wr_addr  in  5  destination index of the instruction in EX
- ex_redirect  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM stage issues a data-memory access this cycle
- mem_ready  in  1  data memory completes the access this cycle
- err_clr  in  1  software/debug clear of the ERR state
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold the IF_ID register
- id_ex_stall  out  1  hold the ID_EX register
- ex_mem_stall  out  1  hold the EX_MEM register
- mem_wb_stall  out  1  hold the MEM_WB register
- if_id_flush  out  1  clear the IF_ID register
- id_ex_flush  out  1  clear the ID_EX register
- ex_mem_flush  out  1  clear the EX_MEM register
- mem_err  out  1  sticky timeout flag (high in ERR)

Behaviour:
- State register: RUN, MEM_WAIT, ERR. Wait counter wcnt is CNT_W bits wide. Outputs are combinational from state, rst and inputs.
- Reset (rst=1, asynchronous): state=RUN, wcnt=0. While rst is high: all *_flush=1, all *_stall=0, mem_err=0.
- load_use = ex_mem_r & (ex_wr_addr!=0) & ((id_rs1_used & id_rs1_addr==ex_wr_addr) | (id_rs2_used & id_rs2_addr==ex_wr_addr)).
- RUN, priority high to low:
  - Memory wait: mem_req & ~mem_ready. Assert all five stalls and no flushes. Next state MEM_WAIT, wcnt<=1.
  - Redirect: ex_redirect=1. if_id_flush=1, id_ex_flush=1, no stalls. Redirect has priority over load_use in the same cycle, because the ID instruction is squashed.
  - Load-use: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble). EX_MEM and MEM_WB advance.
  - Otherwise: all outputs 0.
- MEM_WAIT:
  - All five stalls stay asserted and no flushes, regardless of ex_redirect or load_use. Those inputs are held stable by the frozen registers and are re-evaluated in RUN.
  - mem_ready=1: this cycle is still fully stalled; next state RUN, wcnt<=0.
  - mem_ready=0 with wcnt==MEM_TIMEOUT-1: next state ERR.
  - Otherwise: wcnt<=wcnt+1. The counter saturates and never wraps.
- ERR:
  - All stalls=1, no flushes, mem_err=1.
  - Leaves only on err_clr=1: next state RUN, wcnt<=0, and ex_mem_flush=1 for that cycle to drop the hung access.
  - mem_ready is ignored in ERR.
- Simultaneous mem_req & mem_ready in RUN (single-cycle access): no stall; normal priority applies.
- ex_mem_flush is asserted only on reset and on ERR exit.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN. When defined, adds three 32-bit outputs:
  - perf_mem_stall: cycles spent in MEM_WAIT plus RUN cycles where the memory-wait stall is asserted.
  - perf_lu_bubble: load-use bubbles inserted.
  - perf_redirect: redirect flushes.
- Counters reset to 0 on rst and wrap modulo 2^32.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-MEM_WAIT (wcnt=5) -> outputs go to all flushes=1 and stalls=0 immediately; after release, state=RUN and wcnt=0.
- Load-use: ex_mem_r=1, ex_wr_addr=5, id_rs2_used=1, id_rs2_addr=5 -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle. With ex_wr_addr=0 -> no stall.
- Redirect plus load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> all stalls high for 4 cycles, then RUN. A redirect held during the wait flushes on the first RUN cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> ERR entered after 4 stall cycles and mem_err=1. Then err_clr=1 -> ex_mem_flush=1 for 1 cycle and return to RUN.
- With HAZARD_PERF_CNT_EN defined: 2 bubbles, 1 redirect and a 3-cycle wait -> perf_lu_bubble=2, perf_redirect=1, perf_mem_stall=4.
